imem_fetch_responder: RTL
=========================

Name: imem_fetch_responder

Overview:
- Instruction-memory responder at the memory end of the fetch interface; the PC register is the requesting end and supplies word addresses.
- Accepts one word-address fetch request at a time and returns the 32-bit instruction after a fixed, parameterised latency.
- Uses a valid/ready handshake on both the request and response sides, and supports a pipeline flush.
- Holds its own word storage, which is preloaded through a write port. The region starts at the reset vector, word address 30'h0c00 (byte 0x3000).

Parameters:
- DEPTH, 1024, number of 32-bit instruction words stored; must be a power of two.
- BASE, 30'h0c00, word address of storage entry 0.
- LAT, 2, cycles from request acceptance to response valid; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-low: takes effect on the rising edge of clk while rst==0.
- req_valid  input  1  fetch request present.
- req_addr  input  [31:2]  word address of the instruction (PC).
- req_ready  output  1  responder can accept a request this cycle.
- resp_valid  output  1  instruction response present.
- resp_instr  output  32  fetched instruction.
- resp_err  output  1  address outside [BASE, BASE+DEPTH-1].
- resp_ready  input  1  consumer accepts the response this cycle.
- flush  input  1  discard any in-flight request or response.
- wr_en  input  1  preload write strobe.
- wr_addr  input  [31:2]  preload word address (same address space as req_addr).
- wr_data  input  32  preload data.

Behaviour:
- State machine states: IDLE, WAIT, RESP.
- Outputs per state:
  - req_ready=1 only in IDLE (decoded from state, no combinational path from inputs).
  - resp_valid=1 only in RESP.
  - resp_instr and resp_err are registered and stay stable throughout RESP.
- Reset (rst==0 at an edge):
  - state goes to IDLE; resp_instr=32'h0, resp_err=0, latency counter=0.
  - req_ready=1 and resp_valid=0 from the next cycle.
  - Storage contents are NOT cleared.
  - A reset mid-request drops the request silently.
- Accept: in IDLE with req_valid=1 and flush=0 at an edge.
  - Compute idx = req_addr - BASE (30-bit arithmetic).
  - Out of range when req_addr < BASE or idx >= DEPTH. Out-of-range latches resp_err=1 and resp_instr=32'h0; in-range latches resp_err=0 and resp_instr=mem[idx].
  - Read-before-write: a wr_en to the same index on the accept edge does not affect the latched value.
- Transitions:
  - LAT==1: IDLE->RESP on the accept edge.
  - LAT>1: IDLE->WAIT on the accept edge; counter loads LAT-1, decrements once per edge in WAIT; WAIT->RESP on the edge where the counter is 1.
- Latency: resp_valid rises exactly LAT cycles after the accept edge.
- RESP->IDLE on the edge where resp_ready=1. While resp_ready=0, the response holds indefinitely with unchanged values.
- Throughput: at most one request per LAT+1 cycles; a new request is accepted no earlier than the cycle after the response handshake.
- flush=1 at an edge has priority over everything except reset:
  - Any state goes to IDLE; a response in RESP is dropped even if resp_ready=1 on that edge.
  - In IDLE, a request presented together with flush is not accepted.
- Preload: wr_en=1 with wr_addr in range writes mem[wr_addr-BASE]=wr_data at the edge. Out-of-range writes are ignored. Writes work in every state and during reset.
- Out-of-range requests follow the same timing as in-range requests (no early error).
- resp_instr and resp_err are unspecified outside RESP; the bench must not check them there.

Test Plan:
- Reset then preload: mem[0]=32'h3c010000 and mem[1]=32'h34210004 via wr_en; release rst; request req_addr=30'h0c00 → req_ready drops on the next cycle, resp_valid=1 exactly 2 cycles after acceptance, resp_instr=32'h3c010000, resp_err=0.
- Back-pressure: request 30'h0c01 with resp_ready=0 for 5 cycles → resp_valid and resp_instr=32'h34210004 stay stable; resp_ready=1 → IDLE next cycle, req_ready=1.
- Range errors: req_addr=30'h0bff → resp_err=1, resp_instr=0. req_addr=30'h0c00+DEPTH → resp_err=1, with the same timing as an in-range request.
- Flush: flush during WAIT → IDLE, resp_valid never asserts. Flush in RESP together with resp_ready=1 → response dropped. Flush together with req_valid in IDLE → request not accepted.
- Reset mid-operation: rst=0 while in WAIT → next cycle resp_valid=0 and req_ready=1; a subsequent read of mem[0] still returns the preloaded 32'h3c010000.
- LAT=1 build plus same-index collision: wr_en to mem[2]=32'hAAAAAAAA on the same edge as a request for 30'h0c02 (old value 32'h11111111) → response one cycle later is 32'h11111111; a repeat request returns 32'hAAAAAAAA.

Source files
------------

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: one fetch in flight, fixed-latency reply,
// valid/ready on both sides, flush, and a preload write port.
module imem_fetch_responder #(
    parameter int          DEPTH = 1024,
    parameter logic [29:0] BASE  = 30'h0c00,
    parameter int          LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:2] req_addr,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_instr,
    output logic        resp_err,
    input  logic        resp_ready,
    input  logic        flush,
    input  logic        wr_en,
    input  logic [31:2] wr_addr,
    input  logic [31:0] wr_data
);

    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);
    localparam logic [3:0]  CNT_LD  = 4'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH];

    logic [29:0] rd_idx;
    logic [29:0] wr_idx;
    logic        rd_ok;
    logic        wr_ok;

    assign rd_idx = req_addr - BASE;
    assign wr_idx = wr_addr - BASE;
    assign rd_ok  = (req_addr >= BASE) && (rd_idx < DEPTH_W);
    assign wr_ok  = (wr_addr >= BASE) && (wr_idx < DEPTH_W);

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    // Storage is never reset so a preload survives a core reset.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            mem[wr_idx[IW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            resp_instr <= 32'h0;
            resp_err   <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        resp_err   <= ~rd_ok;
                        resp_instr <= rd_ok ? mem[rd_idx[IW-1:0]] : 32'h0;
                        if (LAT == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state <= RESP;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
